// File: rtl/pattern_model_gen_if.sv
// Model-position bus: pattern load/frame strobe in, per-ball positions out.
interface pattern_model_gen_if;
  logic              start_in;
  logic [6:0][2:0]   pattern_throws;
  logic [2:0]        pattern_len;
  logic [2:0]        num_balls;
  logic              frame_in;
  logic [6:0][10:0]  model_balls_x;
  logic [6:0][9:0]   model_balls_y;
  logic              data_valid_out;
  logic              pattern_err;

  modport master (
    input  start_in, pattern_throws, pattern_len, num_balls, frame_in,
    output model_balls_x, model_balls_y, data_valid_out, pattern_err
  );
  modport slave (
    output start_in, pattern_throws, pattern_len, num_balls, frame_in,
    input  model_balls_x, model_balls_y, data_valid_out, pattern_err
  );
endinterface

// File: rtl/pattern_model_gen.sv
// Siteswap model-position generator: per frame, optionally throws one ball,
// then walks the balls serially computing ideal positions and emits them.
module pattern_model_gen #(
  parameter int BEAT_FRAMES = 15,
  parameter int HAND_L_X    = 480,
  parameter int HAND_R_X    = 800,
  parameter int HAND_Y      = 600,
  parameter int GRAV        = 3
) (
  input logic clk_in,
  input logic rst_in,
  pattern_model_gen_if.master bus
);
  localparam int NB = 7;
  localparam int unsigned SPAN_U = HAND_R_X - HAND_L_X;
  localparam int unsigned GRAV_U = GRAV;
  localparam int unsigned HY_U   = HAND_Y;

  typedef enum logic [1:0] {S_IDLE, S_THROW, S_CALC, S_EMIT} state_e;

  state_e               state_q, state_d;
  logic [2:0]           k_q, k_d, beat_q, beat_d, len_q, len_d, nb_q, nb_d;
  logic                 hand_q, hand_d, vld_q, vld_d, err_q, err_d;
  logic [7:0]           fcnt_q, fcnt_d;
  logic [NB-1:0][2:0]   thr_q, thr_d, h_q, h_d;
  logic [NB-1:0]        launched_q, launched_d, from_q, from_d;
  logic [NB-1:0][6:0]   t_q, t_d;
  logic [NB-1:0][10:0]  wx_q, wx_d, ox_q, ox_d;
  logic [NB-1:0][9:0]   wy_q, wy_d, oy_q, oy_d;

  // floor(65536/(h*BEAT_FRAMES)) per throw height, fixed at elaboration
  logic [7:0][16:0]     recip;
  logic [NB-1:0][9:0]   tf;
  logic [NB-1:0]        held;

  for (genvar i = 0; i < 8; i++) begin : g_recip
    assign recip[i] = (i == 0) ? 17'd0 : 17'(65536 / (i * BEAT_FRAMES));
  end

  for (genvar i = 0; i < NB; i++) begin : g_ball
    assign tf[i]   = 10'(h_q[i]) * 10'(BEAT_FRAMES);
    assign held[i] = launched_q[i] && ({3'b0, t_q[i]} == tf[i]);
  end

  // position of ball k_q from its current (pre-increment) flight state
  int unsigned pt, ptf, dy, off;
  int          px, py;
  always_comb begin
    pt  = 32'(t_q[k_q]);
    ptf = 32'(tf[k_q]);
    dy  = (pt * (ptf - pt) * GRAV_U) >> 4;
    off = (SPAN_U * pt * 32'(recip[h_q[k_q]])) >> 16;
    py  = (dy > HY_U) ? 0 : int'(HY_U - dy);
    px  = from_q[k_q] ? HAND_R_X : HAND_L_X;
    if (!launched_q[k_q]) begin
      px = k_q[0] ? HAND_R_X : HAND_L_X;
      py = HAND_Y;
    end else if (h_q[k_q][0]) begin
      if (pt < ptf) px = from_q[k_q] ? HAND_R_X - int'(off) : HAND_L_X + int'(off);
      else          px = from_q[k_q] ? HAND_L_X : HAND_R_X;
    end
  end

  // catcher choice: held ball landing in the throwing hand first, else a fresh one
  logic [2:0] h_new, sel;
  logic       sel_ok;
  always_comb begin
    h_new  = thr_q[beat_q];
    sel    = 3'd0;
    sel_ok = 1'b0;
    for (int i = NB-1; i >= 0; i--)
      if (held[i] && ((from_q[i] ^ h_q[i][0]) == hand_q)) begin
        sel = 3'(i); sel_ok = 1'b1;
      end
    if (!sel_ok)
      for (int i = NB-1; i >= 0; i--)
        if (!launched_q[i] && (3'(i) < nb_q)) begin
          sel = 3'(i); sel_ok = 1'b1;
        end
  end

  always_comb begin
    state_d = state_q;  k_d = k_q;  beat_d = beat_q;  hand_d = hand_q;
    fcnt_d = fcnt_q;    thr_d = thr_q;  len_d = len_q;  nb_d = nb_q;
    launched_d = launched_q;  from_d = from_q;  t_d = t_q;  h_d = h_q;
    wx_d = wx_q;  wy_d = wy_q;  ox_d = ox_q;  oy_d = oy_q;
    err_d = err_q;  vld_d = 1'b0;
    case (state_q)
      S_IDLE:
        if (bus.frame_in && nb_q != 3'd0) begin
          k_d     = 3'd0;
          state_d = (fcnt_q == 8'd0) ? S_THROW : S_CALC;
        end
      S_THROW: begin
        if (h_new != 3'd0) begin
          if (sel_ok) begin
            t_d[sel] = 7'd0;  h_d[sel] = h_new;
            from_d[sel] = hand_q;  launched_d[sel] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        beat_d  = ({1'b0, beat_q} + 4'd1 >= {1'b0, len_q}) ? 3'd0 : beat_q + 3'd1;
        hand_d  = ~hand_q;
        k_d     = 3'd0;
        state_d = S_CALC;
      end
      S_CALC: begin
        wx_d[k_q] = 11'(px);
        wy_d[k_q] = 10'(py);
        if (k_q == nb_q - 3'd1) state_d = S_EMIT;
        else                    k_d = k_q + 3'd1;
      end
      S_EMIT: begin
        vld_d = 1'b1;
        ox_d  = wx_q;
        oy_d  = wy_q;
        for (int i = 0; i < NB; i++)
          if (launched_q[i] && ({3'b0, t_q[i]} < tf[i])) t_d[i] = t_q[i] + 7'd1;
        fcnt_d  = (fcnt_q == 8'(BEAT_FRAMES - 1)) ? 8'd0 : fcnt_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // restart wins over everything, including a frame in flight
    if (bus.start_in) begin
      thr_d = bus.pattern_throws;  len_d = bus.pattern_len;  nb_d = bus.num_balls;
      launched_d = '0;  from_d = '0;  t_d = '0;  h_d = '0;
      beat_d = 3'd0;  hand_d = 1'b0;  fcnt_d = 8'd0;  err_d = 1'b0;
      wx_d = '0;  wy_d = '0;  ox_d = '0;  oy_d = '0;
      vld_d = 1'b0;  k_d = 3'd0;  state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;  k_q <= 3'd0;  beat_q <= 3'd0;  hand_q <= 1'b0;
      fcnt_q <= 8'd0;  thr_q <= '0;  len_q <= 3'd1;  nb_q <= 3'd0;
      launched_q <= '0;  from_q <= '0;  t_q <= '0;  h_q <= '0;
      wx_q <= '0;  wy_q <= '0;  ox_q <= '0;  oy_q <= '0;
      vld_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  k_q <= k_d;  beat_q <= beat_d;  hand_q <= hand_d;
      fcnt_q <= fcnt_d;  thr_q <= thr_d;  len_q <= len_d;  nb_q <= nb_d;
      launched_q <= launched_d;  from_q <= from_d;  t_q <= t_d;  h_q <= h_d;
      wx_q <= wx_d;  wy_q <= wy_d;  ox_q <= ox_d;  oy_q <= oy_d;
      vld_q <= vld_d;  err_q <= err_d;
    end
  end

  assign bus.model_balls_x  = ox_q;
  assign bus.model_balls_y  = oy_q;
  assign bus.data_valid_out = vld_q;
  assign bus.pattern_err    = err_q;
endmodule

// File: tb/tb_pattern_model_gen.sv
// Bench for pattern_model_gen: timestamp-based juggling model plus directed scenarios.
module tb_pattern_model_gen;
  localparam int BF = 15;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  pattern_model_gen_if pif();
  pattern_model_gen dut (.clk_in(clk_in), .rst_in(rst_in), .bus(pif.master));

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               due;
    int               frame;
    logic [6:0][10:0] x;
    logic [6:0][9:0]  y;
    logic             err;
  } exp_t;
  exp_t exp_q[$];
  exp_t cmp_e;
  int   last_due;

  // model: each ball remembers the frame it was thrown, not a running counter
  bit m_launched[7];
  int m_tt[7], m_h[7], m_from[7], m_thr[7];
  int m_len, m_nb, m_f;
  bit m_err;

  task automatic model_frame(output exp_t e);
    int beat, hand, h, sel, tfl, age, t, dy, yy, off, xx;
    if (m_f % BF == 0) begin
      beat = (m_f / BF) % m_len;
      hand = (m_f / BF) % 2;
      h    = m_thr[beat];
      sel  = -1;
      if (h != 0) begin
        for (int i = 0; i < 7; i++)
          if (sel < 0 && m_launched[i] && (m_f - m_tt[i]) >= m_h[i] * BF &&
              ((m_from[i] ^ (m_h[i] % 2)) == hand)) sel = i;
        for (int i = 0; i < m_nb; i++)
          if (sel < 0 && !m_launched[i]) sel = i;
        if (sel < 0) m_err = 1'b1;
        else begin
          m_launched[sel] = 1'b1; m_tt[sel] = m_f; m_h[sel] = h; m_from[sel] = hand;
        end
      end
    end
    e.frame = m_f;
    e.err   = m_err;
    e.x     = '0;
    e.y     = '0;
    for (int i = 0; i < m_nb; i++) begin
      if (!m_launched[i]) begin
        e.x[i] = (i % 2) ? 11'd800 : 11'd480;
        e.y[i] = 10'd600;
      end else begin
        tfl = m_h[i] * BF;
        age = m_f - m_tt[i];
        t   = (age > tfl) ? tfl : age;
        dy  = (t * (tfl - t) * 3) >> 4;
        yy  = 600 - dy;
        if (yy < 0) yy = 0;
        if (m_h[i] % 2 == 0)  xx = m_from[i] ? 800 : 480;
        else if (t < tfl) begin
          off = (320 * t * (65536 / tfl)) >> 16;
          xx  = m_from[i] ? 800 - off : 480 + off;
        end else xx = m_from[i] ? 480 : 800;
        e.x[i] = 11'(xx);
        e.y[i] = 10'(yy);
      end
    end
    m_f++;
  endtask

  // every cycle: either the expected pulse arrives exactly on time, or no pulse
  always @(negedge clk_in) begin
    if (exp_q.size() != 0 && cyc == exp_q[0].due) begin
      cmp_e = exp_q.pop_front();
      checks++;
      if (pif.data_valid_out !== 1'b1) begin
        errors++;
        $display("FAIL pulse_latency frame=%0d cyc=%0d valid=%b want 1", cmp_e.frame, cyc, pif.data_valid_out);
      end
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (pif.model_balls_x[i] !== cmp_e.x[i] || pif.model_balls_y[i] !== cmp_e.y[i]) begin
          errors++;
          $display("FAIL ball%0d_pos frame=%0d got (%0d,%0d) want (%0d,%0d)", i, cmp_e.frame,
                   pif.model_balls_x[i], pif.model_balls_y[i], cmp_e.x[i], cmp_e.y[i]);
        end
      end
      checks++;
      if (pif.pattern_err !== cmp_e.err) begin
        errors++;
        $display("FAIL pattern_err frame=%0d got %b want %b", cmp_e.frame, pif.pattern_err, cmp_e.err);
      end
    end else begin
      checks++;
      if (pif.data_valid_out !== 1'b0) begin
        errors++;
        $display("FAIL spurious_valid cyc=%0d valid=%b want 0", cyc, pif.data_valid_out);
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic chk_ball(input string name, input int i, input int x, input int y);
    chk({name, "_x"}, int'(pif.model_balls_x[i]), x);
    chk({name, "_y"}, int'(pif.model_balls_y[i]), y);
  endtask

  task automatic do_start(input logic [6:0][2:0] thr, input int len, input int nb);
    pif.pattern_throws = thr;
    pif.pattern_len    = 3'(len);
    pif.num_balls      = 3'(nb);
    pif.start_in       = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      m_thr[i] = int'(thr[i]); m_launched[i] = 1'b0; m_tt[i] = 0; m_h[i] = 0; m_from[i] = 0;
    end
    m_len = len; m_nb = nb; m_f = 0; m_err = 1'b0;
    @(posedge clk_in); #1;
    pif.start_in = 1'b0;
  endtask

  task automatic issue_frame();
    exp_t e;
    int   lat;
    lat = m_nb + ((m_f % BF == 0) ? 3 : 2);
    model_frame(e);
    e.due    = cyc + lat;
    last_due = e.due;
    exp_q.push_back(e);
    pif.frame_in = 1'b1;
    @(posedge clk_in); #1;
    pif.frame_in = 1'b0;
  endtask

  task automatic run_frame();
    issue_frame();
    while (cyc < last_due + 1) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic raw_frame_idle();
    pif.frame_in = 1'b1;
    @(posedge clk_in); #1;
    pif.frame_in = 1'b0;
    repeat (12) @(posedge clk_in);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    for (int i = 0; i < 7; i++) begin
      chk({name, "_x"}, int'(pif.model_balls_x[i]), 0);
      chk({name, "_y"}, int'(pif.model_balls_y[i]), 0);
    end
    chk({name, "_valid"}, int'(pif.data_valid_out), 0);
    chk({name, "_err"}, int'(pif.pattern_err), 0);
  endtask

  logic [6:0][2:0] thr;

  initial begin
    pif.start_in = 1'b0; pif.frame_in = 1'b0; pif.pattern_throws = '0;
    pif.pattern_len = 3'd1; pif.num_balls = 3'd0;
    m_len = 1; m_nb = 0; m_f = 0; m_err = 1'b0;

    // reset state, then frames before any start must be ignored
    repeat (3) @(posedge clk_in);
    #1;
    chk_all_zero("reset");
    rst_in = 1'b1;
    raw_frame_idle();

    // three-ball cascade
    thr = '0; thr[0] = 3'd3;
    do_start(thr, 1, 3);
    for (int f = 0; f <= 46; f++) begin
      run_frame();
      if (f == 0) begin
        chk_ball("casc_f0_b0", 0, 480, 600);
        chk_ball("casc_f0_b1", 1, 800, 600);
        chk_ball("casc_f0_b2", 2, 480, 600);
      end
      if (f == 15) chk_ball("casc_f15_b1", 1, 800, 600);
      if (f == 22) chk_ball("casc_f22_b0", 0, 636, 506);
      if (f == 45) chk_ball("casc_f45_b0", 0, 800, 600);
      if (f == 46) chk_ball("casc_f46_b0", 0, 793, 592);
    end

    // restart mid-CALC aborts the frame; next frame looks like frame 0
    do_start(thr, 1, 3);
    run_frame();
    run_frame();
    issue_frame();
    do_start(thr, 1, 3);
    chk_ball("restart_zero_b1", 1, 0, 0);
    repeat (10) @(posedge clk_in);
    #1;
    run_frame();
    chk_ball("restart_b0", 0, 480, 600);
    chk_ball("restart_b1", 1, 800, 600);
    chk_ball("restart_b2", 2, 480, 600);

    // throw-0 in the middle of the period
    thr = '0; thr[0] = 3'd5; thr[1] = 3'd0; thr[2] = 3'd1;
    do_start(thr, 3, 2);
    for (int f = 0; f <= 47; f++) begin
      run_frame();
      if (f == 15) begin
        chk("zero_f15_err", int'(pif.pattern_err), 0);
        chk_ball("zero_f15_b1", 1, 800, 600);
      end
      if (f == 30) chk_ball("zero_f30_b1", 1, 480, 600);
      if (f == 31) chk_ball("zero_f31_b1", 1, 501, 598);
    end

    // even throw stays on the throwing hand
    thr = '0; thr[0] = 3'd4;
    do_start(thr, 1, 4);
    for (int f = 0; f <= 60; f++) begin
      run_frame();
      chk("even_b0_x", int'(pif.model_balls_x[0]), 480);
      if (f == 30) chk_ball("even_f30_b0", 0, 480, 432);
      if (f == 60) chk("even_f60_b0_y", int'(pif.model_balls_y[0]), 600);
    end

    // invalid pattern: error is sticky and frames keep flowing
    thr = '0; thr[0] = 3'd3;
    do_start(thr, 1, 1);
    for (int f = 0; f <= 20; f++) begin
      run_frame();
      if (f == 14) chk("inv_f14_err", int'(pif.pattern_err), 0);
      if (f == 15) chk("inv_f15_err", int'(pif.pattern_err), 1);
    end

    // reset during CALC kills the frame and clears everything
    issue_frame();
    rst_in = 1'b0;
    exp_q.delete();
    @(posedge clk_in); #1;
    chk_all_zero("midreset");
    rst_in = 1'b1;
    raw_frame_idle();
    chk_all_zero("post_reset_frame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
